particle_update_sequencer: RTL and testbench

PARTICLE_UPDATE_SEQUENCER -- requirements
Module: particle_update_sequencer

---
 rtl/particle_update_sequencer.sv | 121 ++++++++++++
 tb/tb_particle_update_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/particle_update_sequencer.sv
// Verlet position update sweep over a particle memory: read, compute, write back each particle in turn.
// Optional build macro FLOOR_CLAMP_EN clamps the new y (and previous y) to Y_MAX.
module particle_update_sequencer #(
  parameter int               WIDTH       = 32,
  parameter int               N_PARTICLES = 16,
  parameter int               ADDR_W      = 4,
  parameter logic [WIDTH-1:0] GRAVITY     = WIDTH'(32'h00000333),
  parameter logic [WIDTH-1:0] Y_MAX       = WIDTH'(32'h00010000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_x,
  input  logic [WIDTH-1:0]  rd_y,
  input  logic [WIDTH-1:0]  rd_px,
  input  logic [WIDTH-1:0]  rd_py,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_x,
  output logic [WIDTH-1:0]  wr_y,
  output logic [WIDTH-1:0]  wr_px,
  output logic [WIDTH-1:0]  wr_py
);

  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PARTICLES - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] i_reg, i_next;
  logic [WIDTH-1:0]  x_reg, y_reg, px_reg, py_reg;
  logic [WIDTH-1:0]  x_next, y_next, px_next, py_next;
  logic [WIDTH-1:0]  y_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      i_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          i_next     = '0;
          state_next = READ;
        end
      end
      READ:  state_next = CALC;
      CALC:  state_next = WRITE;
      WRITE: begin
        if (wr_ready) begin
          if (i_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            i_next     = i_reg + 1'b1;
            state_next = READ;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory data is valid during CALC, so the new positions are formed from it there.
  always_comb begin
    x_next  = (rd_x << 1) - rd_px;
    y_raw   = (rd_y << 1) - rd_py + GRAVITY;
    px_next = rd_x;
    y_next  = y_raw;
    py_next = rd_y;
`ifdef FLOOR_CLAMP_EN
    if ($signed(y_raw) > $signed(Y_MAX)) begin
      y_next  = Y_MAX;
      py_next = Y_MAX;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg  <= '0;
      y_reg  <= '0;
      px_reg <= '0;
      py_reg <= '0;
    end else if (state_reg == CALC) begin
      x_reg  <= x_next;
      y_reg  <= y_next;
      px_reg <= px_next;
      py_reg <= py_next;
    end
  end

  always_comb begin
    busy  = (state_reg != IDLE);
    done  = (state_reg == DONE);
    rd_en = (state_reg == READ);
    wr_en = (state_reg == WRITE);
  end

  // Address outputs follow the index directly; it is zero whenever reset is active.
  assign rd_addr = i_reg;
  assign wr_addr = i_reg;
  assign wr_x    = x_reg;
  assign wr_y    = y_reg;
  assign wr_px   = px_reg;
  assign wr_py   = py_reg;

endmodule

// File: tb/tb_particle_update_sequencer.sv
// Scoreboard bench for particle_update_sequencer: memory responder, write monitor and sweep stimulus.
module tb_particle_update_sequencer;
  localparam int          N    = 4;
  localparam int          AW   = 2;
  localparam logic [31:0] GRAV = 32'h00000333;
  localparam logic [31:0] YMAX = 32'h00010000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          wr_ready = 1'b1;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rd_x = '0, rd_y = '0, rd_px = '0, rd_py = '0;
  logic [31:0]   wr_x, wr_y, wr_px, wr_py;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_rd = 0;

  logic [31:0] mem_x [N];
  logic [31:0] mem_y [N];
  logic [31:0] mem_px[N];
  logic [31:0] mem_py[N];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   px;
    logic [31:0]   py;
  } wr_t;

  wr_t exp_q[$];

  particle_update_sequencer #(
    .WIDTH(32), .N_PARTICLES(N), .ADDR_W(AW), .GRAVITY(GRAV), .Y_MAX(YMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y), .rd_px(rd_px), .rd_py(rd_py),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_px(wr_px), .wr_py(wr_py)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Reference: Verlet step on the particle as it sits in memory before the sweep.
  function automatic wr_t model(input int a);
    wr_t r;
    logic [31:0] ny;
    r.addr = AW'(a);
    r.x    = 32'(2 * mem_x[a]) - mem_px[a];
    ny     = 32'(2 * mem_y[a]) - mem_py[a] + GRAV;
    r.px   = mem_x[a];
    r.y    = ny;
    r.py   = mem_y[a];
`ifdef FLOOR_CLAMP_EN
    if ($signed(ny) > $signed(YMAX)) begin
      r.y  = YMAX;
      r.py = YMAX;
    end
`endif
    return r;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_x"}, wr_x, 0);
    check({tag, "_wr_y"}, wr_y, 0);
    check({tag, "_wr_px"}, wr_px, 0);
    check({tag, "_wr_py"}, wr_py, 0);
  endtask

  // Memory responder: data appears the cycle after rd_en.
  initial begin : responder
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (rd_en && rst_n) begin
        a = rd_addr;
        @(posedge clk);
        #1;
        rd_x  = mem_x[a];
        rd_y  = mem_y[a];
        rd_px = mem_px[a];
        rd_py = mem_py[a];
      end
    end
  end

  // Monitor: checks read order, stall hold and every accepted write against the scoreboard.
  initial begin : monitor
    wr_t   e, cur, snap;
    logic  stall_prev;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (rd_en) begin
          check("rd_addr_order", rd_addr, exp_rd);
          exp_rd = (exp_rd + 1) % N;
        end
        cur = '{addr: wr_addr, x: wr_x, y: wr_y, px: wr_px, py: wr_py};
        if (wr_en && stall_prev) check("stall_hold", cur == snap, 1);
        if (wr_en && !wr_ready) begin
          stall_prev = 1'b1;
          snap = cur;
        end else begin
          stall_prev = 1'b0;
        end
        if (wr_en && wr_ready) begin
          $display("write addr=%0d x=%h y=%h px=%h py=%h", wr_addr, wr_x, wr_y, wr_px, wr_py);
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_x", wr_x, e.x);
            check("wr_y", wr_y, e.y);
            check("wr_px", wr_px, e.px);
            check("wr_py", wr_py, e.py);
          end
          mem_x[wr_addr]  = wr_x;
          mem_y[wr_addr]  = wr_y;
          mem_px[wr_addr] = wr_px;
          mem_py[wr_addr] = wr_py;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
  endtask

  // mode 0: wr_ready=1; mode 1: random wr_ready; mode 2: 5-cycle stall on the first write.
  task automatic run_sweep(input int mode, input int exp_cyc, input bit spam);
    int   cyc;
    int   stall_left;
    bit   got_done;
    logic busy_ok;
    for (int a = 0; a < N; a++) exp_q.push_back(model(a));
    pulse_start();
    cyc = 0;
    got_done = 0;
    busy_ok = 1'b1;
    stall_left = (mode == 2) ? 5 : 0;
    while (!got_done && cyc < 300) begin
      cyc++;
      if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && wr_en && stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
      end else wr_ready = 1'b1;
      start = spam && (cyc % 3 == 0);
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) got_done = 1;
      else begin
        @(posedge clk); #2;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    if (exp_cyc >= 0) check("done_cycle", cyc, exp_cyc);
    check("busy_during_sweep", busy_ok, 1);
    @(posedge clk); #2;
    start = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : stimulus
    bit   found;
    logic seen;

    mem_x[0] = 32'h100;      mem_px[0] = 32'hF0; mem_y[0] = 32'h1000; mem_py[0] = 32'h1000;
    mem_x[1] = 32'h80000000; mem_px[1] = 32'h0;  mem_y[1] = 32'h0;    mem_py[1] = 32'h0;
    mem_x[2] = 32'h0;        mem_px[2] = 32'h1;  mem_y[2] = 32'h0;    mem_py[2] = 32'h0;
    mem_x[3] = 32'h0;        mem_px[3] = 32'h0;  mem_y[3] = 32'hFFF0; mem_py[3] = 32'hFF00;

    #1 rst_n = 1'b0;
    #2 check_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    run_sweep(0, 13, 0);
    check("basic_x", mem_x[0], 32'h110);
    check("basic_px", mem_px[0], 32'h100);
    check("basic_y", mem_y[0], 32'h1333);
    check("basic_py", mem_py[0], 32'h1000);
    check("wrap_hi", mem_x[1], 32'h0);
    check("wrap_lo", mem_x[2], 32'hFFFFFFFF);
`ifdef FLOOR_CLAMP_EN
    check("floor_y", mem_y[3], 32'h10000);
    check("floor_py", mem_py[3], 32'h10000);
`else
    check("floor_y", mem_y[3], 32'h10413);
    check("floor_py", mem_py[3], 32'hFFF0);
`endif

    run_sweep(2, 18, 1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || wr_en) seen = 1'b1;
    end
    check("no_extra_sweep", seen, 0);

    for (int a = 0; a < N; a++) exp_q.push_back(model(a));
    pulse_start();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 2) found = 1;
    end
    check("reach_particle2", found, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    exp_q.delete();
    exp_rd = 0;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en || busy) seen = 1'b1;
    end
    check("quiet_after_reset", seen, 0);

    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < N; a++) begin
        mem_x[a]  = $urandom;
        mem_px[a] = $urandom;
        mem_y[a]  = (s % 2 == 0) ? $urandom : 32'($urandom_range(0, 32'h20000));
        mem_py[a] = (s % 2 == 0) ? $urandom : 32'($urandom_range(0, 32'h20000));
      end
      run_sweep(1, -1, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
